// File: rtl/oai_lane_toggle_mon.sv
// oai_lane_toggle_mon: LANES independent registered OAI functions.
// Each lane is the NAND of GROUPS OR-groups, and each OR-group has GROUP_W inputs.
// A windowed monitor counts how many registered QN bits change during a window.
// The toggle count saturates at all ones and raises SAT.
// Build option: define OAI_RISE_ONLY_EN to count only 0->1 transitions of QN.
module oai_lane_toggle_mon #(
    parameter int LANES   = 4,
    parameter int GROUPS  = 2,
    parameter int GROUP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [LANES*GROUPS*GROUP_W-1:0]   IN,
    input  logic                              IN_VALID,
    output logic [LANES-1:0]                  QN,
    output logic                              QN_VALID,
    input  logic                              START,
    input  logic [CNT_W-1:0]                  WINDOW,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [CNT_W-1:0]                  TOG_CNT,
    output logic                              SAT
);

    localparam int IN_W = LANES * GROUPS * GROUP_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Per-lane OAI: NAND across groups of the OR within each group.
    function automatic logic [LANES-1:0] oai_eval(input logic [IN_W-1:0] v);
        logic [LANES-1:0] r;
        logic             all_or;
        logic             any;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            all_or = 1'b1;
            for (int g = 0; g < GROUPS; g++) begin
                any = 1'b0;
                for (int k = 0; k < GROUP_W; k++) begin
                    any = any | v[(l*GROUPS+g)*GROUP_W+k];
                end
                all_or = all_or & any;
            end
            r[l] = ~all_or;
        end
        return r;
    endfunction

    // Number of set bits, widened to the adder width.
    function automatic logic [CNT_W:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W:0] p;
        p = '0;
        for (int i = 0; i < LANES; i++) begin
            p = p + {{CNT_W{1'b0}}, v[i]};
        end
        return p;
    endfunction

    // Saturating add. The MSB of the result flags an overflow.
    // When it is set, the low CNT_W bits are clamped to all ones.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + b;
        if (s[CNT_W]) begin
            return {1'b1, {CNT_W{1'b1}}};
        end
        return s;
    endfunction

    logic [LANES-1:0] qn_next_p0;
    logic [LANES-1:0] edges_p0;
    logic [CNT_W:0]   tog_p0;
    logic [CNT_W:0]   acc_p0;
    logic [LANES-1:0] qn_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] remaining;
    state_t           state;
    state_t           state_nxt;

    // ---- stage p0: combinational OAI evaluation and toggle term ----
    assign qn_next_p0 = oai_eval(IN);

`ifdef OAI_RISE_ONLY_EN
    assign edges_p0 = ~qn_p1 & qn_next_p0;
`else
    assign edges_p0 = qn_p1 ^ qn_next_p0;
`endif

    assign tog_p0 = IN_VALID ? popcount(edges_p0) : '0;
    assign acc_p0 = sat_add(TOG_CNT, tog_p0);

    // ---- stage p1: registered QN and its valid qualifier ----
    // Load QN on a valid input and hold it otherwise; the valid qualifier is delayed by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            qn_p1  <= '1;
            vld_p1 <= 1'b0;
        end else begin
            if (IN_VALID) begin
                qn_p1 <= qn_next_p0;
            end
            vld_p1 <= IN_VALID;
        end
    end

    assign QN       = qn_p1;
    assign QN_VALID = vld_p1;

    // State register for the measurement window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode; START matters only in IDLE.
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = (WINDOW != '0) ? S_COUNT : S_DONE;
                end
            end
            S_COUNT: begin
                BUSY = 1'b1;
                if (remaining == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Window bookkeeping: start clears the counter, and COUNT accumulates and decrements.
    always_ff @(posedge CLK) begin
        if (RST) begin
            remaining <= '0;
            TOG_CNT   <= '0;
            SAT       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        remaining <= WINDOW;
                        TOG_CNT   <= '0;
                        SAT       <= 1'b0;
                    end
                end
                S_COUNT: begin
                    TOG_CNT   <= acc_p0[CNT_W-1:0];
                    SAT       <= SAT | acc_p0[CNT_W];
                    remaining <= remaining - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oai_lane_toggle_mon.sv
// Testbench for oai_lane_toggle_mon (default 16-bit counter plus a 4-bit counter instance).
module tb_oai_lane_toggle_mon;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] IN;
    logic        IN_VALID;
    logic        START;
    logic [15:0] WINDOW;
    logic        START_S;
    logic [3:0]  WINDOW_S;

    logic [3:0]  QN, QN_S;
    logic        QN_VALID, QN_VALID_S;
    logic        BUSY, DONE, SAT;
    logic        BUSY_S, DONE_S, SAT_S;
    logic [15:0] TOG_CNT;
    logic [3:0]  TOG_CNT_S;

    oai_lane_toggle_mon #(.LANES(4), .GROUPS(2), .GROUP_W(2), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .QN(QN), .QN_VALID(QN_VALID),
        .START(START), .WINDOW(WINDOW), .BUSY(BUSY), .DONE(DONE), .TOG_CNT(TOG_CNT), .SAT(SAT)
    );

    oai_lane_toggle_mon #(.LANES(4), .GROUPS(2), .GROUP_W(2), .CNT_W(4)) dut_s (
        .CLK(CLK), .RST(RST), .IN(IN), .IN_VALID(IN_VALID), .QN(QN_S), .QN_VALID(QN_VALID_S),
        .START(START_S), .WINDOW(WINDOW_S), .BUSY(BUSY_S), .DONE(DONE_S), .TOG_CNT(TOG_CNT_S),
        .SAT(SAT_S)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] cnt;
        logic        sat;
    } tog_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] qn_q[$];
    tog_t       tog_q[$];
    logic [3:0] m_qn;

`ifdef OAI_RISE_ONLY_EN
    localparam int EXP_WIN  = 8;
    localparam int EXP_GAPS = 4;
`else
    localparam int EXP_WIN  = 16;
    localparam int EXP_GAPS = 12;
`endif

    function automatic logic [3:0] model_oai(input logic [15:0] v);
        logic [3:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l] = ~((v[4*l] | v[4*l+1]) & (v[4*l+2] | v[4*l+3]));
        end
        return r;
    endfunction

    function automatic int model_tog(input logic [3:0] o, input logic [3:0] n);
`ifdef OAI_RISE_ONLY_EN
        return $countones(~o & n);
`else
        return $countones(o ^ n);
`endif
    endfunction

    task automatic apply(input logic [15:0] v, input logic vld, output int t);
        logic [3:0] nq;
        IN       = v;
        IN_VALID = vld;
        t        = 0;
        if (vld) begin
            nq   = model_oai(v);
            t    = model_tog(m_qn, nq);
            m_qn = nq;
            qn_q.push_back(nq);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_tog(input int acc);
        tog_t e;
        e.cnt = acc[15:0];
        e.sat = 1'b0;
        tog_q.push_back(e);
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge CLK) begin : mon
        logic [3:0] eq;
        tog_t       et;
        if (QN_VALID === 1'b1) begin
            n_cmp++;
            if (qn_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_qn: unexpected QN_VALID, QN=%b, no expected value", QN);
            end else begin
                eq = qn_q.pop_front();
                if (QN !== eq) begin
                    n_err++;
                    $display("FAIL sb_qn: got %b expected %b", QN, eq);
                end
            end
        end
        if (DONE === 1'b1) begin
            n_cmp++;
            if (tog_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_done: unexpected DONE, TOG_CNT=%0d", TOG_CNT);
            end else begin
                et = tog_q.pop_front();
                if (TOG_CNT !== et.cnt || SAT !== et.sat) begin
                    n_err++;
                    $display("FAIL sb_done: got cnt=%0d sat=%b expected cnt=%0d sat=%b",
                             TOG_CNT, SAT, et.cnt, et.sat);
                end
            end
        end
    end

    task automatic test_reset();
        RST = 1'b1; IN = 16'hFFFF; IN_VALID = 1'b1;
        START = 1'b0; WINDOW = '0; START_S = 1'b0; WINDOW_S = '0;
        step();
        step();
        n_cmp++;
        if ({QN, QN_VALID, BUSY, DONE, SAT} !== {4'b1111, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_ctrl: got QN=%b V=%b B=%b D=%b S=%b expected 1111 0 0 0 0",
                     QN, QN_VALID, BUSY, DONE, SAT);
        end
        n_cmp++;
        if (TOG_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d expected 0", TOG_CNT);
        end
        n_cmp++;
        if ({QN_S, QN_VALID_S, BUSY_S, DONE_S, SAT_S, TOG_CNT_S} !== {4'b1111, 4'b0000, 4'd0}) begin
            n_err++;
            $display("FAIL reset_small: got QN=%b V=%b B=%b D=%b S=%b C=%0d expected 1111 0 0 0 0 0",
                     QN_S, QN_VALID_S, BUSY_S, DONE_S, SAT_S, TOG_CNT_S);
        end
        m_qn = 4'hF;
        qn_q.delete();
        tog_q.delete();
        RST = 1'b0;
    endtask

    task automatic test_function();
        int t;
        apply(16'h0005, 1'b1, t);
        step();
        n_cmp++;
        if (QN !== 4'b1110 || QN_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL func_load: got QN=%b V=%b expected 1110 1", QN, QN_VALID);
        end
        apply(16'hFFFF, 1'b0, t);
        step();
        n_cmp++;
        if (QN !== 4'b1110 || QN_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL func_hold: got QN=%b V=%b expected 1110 0", QN, QN_VALID);
        end
    endtask

    task automatic test_window();
        logic [15:0] vecs [4];
        int t, acc, busy_n, done_n;
        vecs[0] = 16'hFFFF; vecs[1] = 16'h0000; vecs[2] = 16'hFFFF; vecs[3] = 16'h0000;
        apply(16'h0000, 1'b1, t);
        step();
        START = 1'b1; WINDOW = 16'd4;
        apply(16'h1234, 1'b0, t);
        step();
        START = 1'b0;
        acc = 0; busy_n = 0; done_n = 0;
        for (int i = 0; i < 4; i++) begin
            busy_n += int'(BUSY);
            done_n += int'(DONE);
            apply(vecs[i], 1'b1, t);
            acc += t;
            if (i == 3) push_tog(acc);
            step();
        end
        n_cmp++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || busy_n != 4 || done_n != 0) begin
            n_err++;
            $display("FAIL win_timing: got DONE=%b BUSY=%b busy_cycles=%0d early_done=%0d expected 1 0 4 0",
                     DONE, BUSY, busy_n, done_n);
        end
        apply(16'h0000, 1'b0, t);
        step();
        n_cmp++;
        if (DONE !== 1'b0 || TOG_CNT !== 16'(EXP_WIN) || SAT !== 1'b0 || acc != EXP_WIN) begin
            n_err++;
            $display("FAIL win_count: got DONE=%b TOG_CNT=%0d SAT=%b model=%0d expected 0 %0d 0",
                     DONE, TOG_CNT, SAT, acc, EXP_WIN);
        end
    endtask

    task automatic test_gaps();
        int t, acc, busy_n, done_n;
        logic [15:0] v;
        START = 1'b1; WINDOW = 16'd6;
        apply(16'h1234, 1'b0, t);
        step();
        acc = 0; busy_n = 0; done_n = 0;
        for (int i = 0; i < 6; i++) begin
            busy_n += int'(BUSY);
            done_n += int'(DONE);
            START = (i == 2);
            if (i % 2 == 1) v = 16'h5A5A;
            else if (i == 2) v = 16'h0000;
            else v = 16'hFFFF;
            apply(v, (i % 2 == 0), t);
            acc += t;
            if (i == 5) push_tog(acc);
            step();
        end
        n_cmp++;
        if (DONE !== 1'b1 || busy_n != 6 || done_n != 0) begin
            n_err++;
            $display("FAIL gaps_timing: got DONE=%b busy_cycles=%0d early_done=%0d expected 1 6 0",
                     DONE, busy_n, done_n);
        end
        // START held during the DONE cycle must not open a window.
        START = 1'b1;
        apply(16'h0000, 1'b0, t);
        step();
        START = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 3; i++) begin
            busy_n += int'(BUSY);
            done_n += int'(DONE);
            step();
        end
        n_cmp++;
        if (busy_n != 0 || done_n != 0 || TOG_CNT !== 16'(EXP_GAPS) || acc != EXP_GAPS) begin
            n_err++;
            $display("FAIL gaps_count: got busy=%0d done=%0d TOG_CNT=%0d model=%0d expected 0 0 %0d",
                     busy_n, done_n, TOG_CNT, acc, EXP_GAPS);
        end
    endtask

    task automatic test_saturation();
        int t, acc;
        START_S = 1'b1; WINDOW_S = 4'd8;
        apply(16'h1234, 1'b0, t);
        step();
        START_S = 1'b0;
        n_cmp++;
        if (BUSY_S !== 1'b1) begin
            n_err++;
            $display("FAIL sat_busy: got %b expected 1", BUSY_S);
        end
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            apply((i % 2 == 0) ? 16'h0000 : 16'hFFFF, 1'b1, t);
            acc += t;
            step();
        end
        n_cmp++;
        if (DONE_S !== 1'b1 || TOG_CNT_S !== 4'hF || SAT_S !== 1'b1 || acc <= 15) begin
            n_err++;
            $display("FAIL sat_clamp: got DONE=%b TOG_CNT=%0d SAT=%b raw=%0d expected 1 15 1 >15",
                     DONE_S, TOG_CNT_S, SAT_S, acc);
        end
        apply(16'h0000, 1'b0, t);
        step();
        n_cmp++;
        if (TOG_CNT_S !== 4'hF || SAT_S !== 1'b1 || DONE_S !== 1'b0) begin
            n_err++;
            $display("FAIL sat_hold: got TOG_CNT=%0d SAT=%b DONE=%b expected 15 1 0",
                     TOG_CNT_S, SAT_S, DONE_S);
        end
        START_S = 1'b1; WINDOW_S = 4'd0;
        step();
        START_S = 1'b0;
        n_cmp++;
        if (DONE_S !== 1'b1 || BUSY_S !== 1'b0 || TOG_CNT_S !== 4'd0 || SAT_S !== 1'b0) begin
            n_err++;
            $display("FAIL empty_win: got DONE=%b BUSY=%b TOG_CNT=%0d SAT=%b expected 1 0 0 0",
                     DONE_S, BUSY_S, TOG_CNT_S, SAT_S);
        end
        step();
        n_cmp++;
        if (DONE_S !== 1'b0) begin
            n_err++;
            $display("FAIL empty_pulse: got DONE=%b expected 0", DONE_S);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        for (int i = 0; i < 40; i++) begin
            apply(16'($urandom), ($urandom_range(0, 3) != 0), t);
            step();
        end
        apply(16'h0000, 1'b0, t);
        step();
    endtask

    task automatic test_reset_mid();
        int t, acc, done_n;
        START = 1'b1; WINDOW = 16'd10;
        apply(16'h1234, 1'b0, t);
        step();
        START = 1'b0;
        apply(16'hFFFF, 1'b1, t);
        step();
        apply(16'h0000, 1'b1, t);
        step();
        RST = 1'b1; IN = 16'hFFFF; IN_VALID = 1'b1;
        step();
        m_qn = 4'hF;
        n_cmp++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || TOG_CNT !== 16'd0 || SAT !== 1'b0 ||
            QN !== 4'hF || QN_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got B=%b D=%b C=%0d S=%b QN=%b V=%b expected 0 0 0 0 1111 0",
                     BUSY, DONE, TOG_CNT, SAT, QN, QN_VALID);
        end
        RST = 1'b0;
        apply(16'h0000, 1'b0, t);
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            done_n += int'(DONE) + int'(BUSY);
        end
        n_cmp++;
        if (done_n != 0) begin
            n_err++;
            $display("FAIL rst_nodone: got %0d DONE/BUSY cycles expected 0", done_n);
        end
        START = 1'b1; WINDOW = 16'd3;
        step();
        START = 1'b0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            apply(16'($urandom), 1'b1, t);
            acc += t;
            if (i == 2) push_tog(acc);
            step();
        end
        n_cmp++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || TOG_CNT !== 16'(acc)) begin
            n_err++;
            $display("FAIL rst_rerun: got DONE=%b BUSY=%b TOG_CNT=%0d expected 1 0 %0d",
                     DONE, BUSY, TOG_CNT, acc);
        end
        apply(16'h0000, 1'b0, t);
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_function();
        test_window();
        test_gaps();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (qn_q.size() != 0 || tog_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d qn and %0d done entries left expected 0 0",
                     qn_q.size(), tog_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
